// File: rtl/nv_nvdla_sdp_rdma_rd_arb.sv
// Round-robin arbiter sharing one SDP DMA read channel among NREQ read engines.
// An in-order context queue records each accepted request's owner and atom count so beats route back.
//
// state   | meaning
// ST_ARB  | grant recomputed from rr_ptr every cycle
// ST_HOLD | request presented but not accepted; grant frozen until accept
module nv_nvdla_sdp_rdma_rd_arb #(
  parameter int NREQ     = 4,
  parameter int REQ_W    = 79,
  parameter int RSP_W    = 514,
  parameter int CQ_DEPTH = 8
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic [NREQ-1:0]         arb_en,
  input  logic [NREQ-1:0]         req_vld,
  input  logic [NREQ*REQ_W-1:0]   req_pd,
  input  logic [NREQ-1:0]         req_ram_type,
  output logic [NREQ-1:0]         req_rdy,
  output logic                    dma_rd_req_vld,
  output logic [REQ_W-1:0]        dma_rd_req_pd,
  output logic                    dma_rd_req_ram_type,
  input  logic                    dma_rd_req_rdy,
  input  logic                    dma_rd_rsp_vld,
  input  logic [RSP_W-1:0]        dma_rd_rsp_pd,
  output logic                    dma_rd_rsp_rdy,
  output logic [NREQ-1:0]         rsp_vld,
  output logic [RSP_W-1:0]        rsp_pd,
  input  logic [NREQ-1:0]         rsp_rdy,
  output logic                    arb_idle,
  output logic                    err_unexp_rsp
);

  localparam int         AW      = $clog2(CQ_DEPTH);
  localparam logic [AW:0] CQ_FULL = (AW+1)'(CQ_DEPTH);
  localparam logic [1:0] LAST    = 2'(NREQ-1);

  typedef enum logic {ST_ARB, ST_HOLD} state_t;

  state_t           state, state_nxt;
  logic             hold;
  logic [NREQ-1:0]  elig;
  logic [1:0]       rr_ptr, rr_g, held_g, grant;
  logic             rr_found;
  logic [2:0]       scan_idx;
  logic             cand_vld;
  logic             req_accept;
  logic [REQ_W-1:0] sel_pd;
  logic             sel_ram;

  logic [1:0]       cq_id    [CQ_DEPTH];
  logic [15:0]      cq_atoms [CQ_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cq_count;
  logic             cq_empty, cq_full;
  logic [1:0]       head_id;
  logic [15:0]      head_rem, cur_rem, beat_cnt, push_atoms;
  logic             head_loaded;
  logic [1:0]       rsp_mask;
  logic             rsp_beat, head_done, cq_pop;

  assign elig = req_vld & arb_en;

  // Scan starting at rr_ptr, wrapping at NREQ (which need not be a power of 2).
  always_comb begin
    rr_g     = '0;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + 3'(k);
      if (scan_idx >= 3'(NREQ)) scan_idx = scan_idx - 3'(NREQ);
      if (!rr_found && elig[scan_idx[1:0]]) begin
        rr_found = 1'b1;
        rr_g     = scan_idx[1:0];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state <= ST_ARB;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_ARB;
    if (dma_rd_req_vld && !dma_rd_req_rdy) state_nxt = ST_HOLD;
  end

  always_comb begin
    hold = (state == ST_HOLD);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      held_g <= '0;
      rr_ptr <= '0;
    end else begin
      if (state_nxt == ST_HOLD) held_g <= grant;
      if (req_accept) rr_ptr <= (grant == LAST) ? 2'd0 : grant + 2'd1;
    end
  end

  assign grant          = hold ? held_g : rr_g;
  assign cand_vld       = hold ? req_vld[held_g] : |elig;
  assign dma_rd_req_vld = cand_vld & ~cq_full;
  assign req_accept     = dma_rd_req_vld & dma_rd_req_rdy;

  always_comb begin
    sel_pd  = '0;
    sel_ram = 1'b0;
    req_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == i[1:0]) begin
        sel_pd     = req_pd[i*REQ_W +: REQ_W];
        sel_ram    = req_ram_type[i];
        req_rdy[i] = req_accept;
      end
    end
  end

  assign dma_rd_req_pd       = dma_rd_req_vld ? sel_pd : '0;
  assign dma_rd_req_ram_type = dma_rd_req_vld & sel_ram;
  assign push_atoms          = 16'(dma_rd_req_pd[REQ_W-1 -: 15]) + 16'd1;

  assign cq_empty = (cq_count == '0);
  assign cq_full  = (cq_count == CQ_FULL);
  assign head_id  = cq_id[rd_ptr];
  assign cur_rem  = head_loaded ? head_rem : cq_atoms[rd_ptr];
  assign rsp_mask = dma_rd_rsp_pd[RSP_W-1 -: 2];
  assign beat_cnt = 16'(rsp_mask[1]) + 16'(rsp_mask[0]);

  // An empty queue keeps ready high so stray beats drain instead of stalling the dmaif.
  assign dma_rd_rsp_rdy = cq_empty | rsp_rdy[head_id];
  assign rsp_beat       = dma_rd_rsp_vld & dma_rd_rsp_rdy & ~cq_empty;
  assign head_done      = (cur_rem <= beat_cnt);
  assign cq_pop         = rsp_beat & head_done;
  assign rsp_pd         = cq_empty ? '0 : dma_rd_rsp_pd;

  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < NREQ; i++)
      rsp_vld[i] = dma_rd_rsp_vld & ~cq_empty & (head_id == i[1:0]);
  end

  assign arb_idle = cq_empty & ~(|elig);

  always_ff @(posedge nvdla_core_clk) begin
    if (req_accept) begin
      cq_id[wr_ptr]    <= grant;
      cq_atoms[wr_ptr] <= push_atoms;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cq_count      <= '0;
      head_rem      <= '0;
      head_loaded   <= 1'b0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (req_accept) wr_ptr <= wr_ptr + AW'(1);
      if (cq_pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({req_accept, cq_pop})
        2'b10:   cq_count <= cq_count + (AW+1)'(1);
        2'b01:   cq_count <= cq_count - (AW+1)'(1);
        default: ;
      endcase
      // Clearing head_loaded makes the next head's atom count take effect on the pop edge.
      if (rsp_beat) begin
        if (head_done) begin
          head_loaded <= 1'b0;
        end else begin
          head_rem    <= cur_rem - beat_cnt;
          head_loaded <= 1'b1;
        end
      end
      if (cq_empty && dma_rd_rsp_vld) err_unexp_rsp <= 1'b1;
    end
  end

endmodule
